// File: rtl/bus_sync_rx_mc.sv
// Destination-side receiver for toggle-handshake bus synchronisation.
// Each channel synchronises a request toggle, captures the held word and offers it on valid/ready.
module bus_sync_rx_mc #(
    parameter int DWIDTH      = 32,
    parameter int NCH         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_MODE    = 0
) (
    input  logic                  i_clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        i_req_tgl,
    input  logic [NCH*DWIDTH-1:0] i_src_data,
    output logic [NCH-1:0]        o_ack_tgl,
    output logic [NCH*DWIDTH-1:0] o_data,
    output logic [NCH-1:0]        o_valid,
    input  logic [NCH-1:0]        i_ready,
    output logic [NCH-1:0]        o_pend
);

    // state    | meaning
    // ST_EMPTY | output register free, next synchronised request edge is captured
    // ST_FULL  | output register holds an unconsumed word (o_valid high)
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("bus_sync_rx_mc: SYNC_STAGES must be at least 2");
        end
    endgenerate

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_req_seen;
            logic                   r_ack;
            logic [DWIDTH-1:0]      r_data;
            state_t                 r_state;
            state_t                 w_state_nxt;
            logic                   w_edge;
            logic                   w_capture;
            logic                   w_ack_flip;

            always_ff @(posedge i_clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], i_req_tgl[c]};
                end
            end

            // Level compare against the last accepted toggle, so an edge held off by backpressure is kept.
            assign w_edge = r_sync[SYNC_STAGES-1] ^ r_req_seen;

            always_comb begin
                w_state_nxt = r_state;
                w_capture   = 1'b0;
                w_ack_flip  = 1'b0;
                case (r_state)
                    ST_EMPTY: begin
                        if (w_edge) begin
                            w_capture   = 1'b1;
                            w_ack_flip  = (ACK_MODE == 0);
                            w_state_nxt = ST_FULL;
                        end
                    end
                    ST_FULL: begin
                        if (i_ready[c]) begin
                            if (w_edge && (ACK_MODE == 0)) begin
                                w_capture  = 1'b1;
                                w_ack_flip = 1'b1;
                            end else begin
                                w_ack_flip  = (ACK_MODE != 0);
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                    end
                endcase
            end

            always_ff @(posedge i_clk or posedge rst) begin
                if (rst) begin
                    r_state    <= ST_EMPTY;
                    r_req_seen <= 1'b0;
                    r_ack      <= 1'b0;
                    r_data     <= '0;
                end else begin
                    r_state <= w_state_nxt;
                    if (w_capture) begin
                        r_req_seen <= ~r_req_seen;
                        r_data     <= i_src_data[c*DWIDTH +: DWIDTH];
                    end
                    if (w_ack_flip) begin
                        r_ack <= ~r_ack;
                    end
                end
            end

            assign o_data[c*DWIDTH +: DWIDTH] = r_data;
            assign o_valid[c]                 = (r_state == ST_FULL);
            assign o_pend[c]                  = (r_state == ST_FULL) & w_edge;
            assign o_ack_tgl[c]               = r_ack;
        end
    endgenerate

endmodule

// File: tb/tb_bus_sync_rx_mc.sv
// Bench for bus_sync_rx_mc: three instances (early ack, late ack, 3-stage sync) against a
// transaction-level model that timestamps each request and applies the handshake rules.
module tb_bus_sync_rx_mc;

    logic         i_clk = 1'b0;
    logic         rst;

    logic [3:0]   req0, req1, ack0, ack1, val0, val1, rdy0, rdy1, pend0, pend1;
    logic [127:0] src0, src1, dat0, dat1;
    logic [0:0]   req2, ack2, val2, rdy2, pend2;
    logic [7:0]   src2, dat2;

    bus_sync_rx_mc #(.DWIDTH(32), .NCH(4), .SYNC_STAGES(2), .ACK_MODE(0)) dut0 (
        .i_clk(i_clk), .rst(rst), .i_req_tgl(req0), .i_src_data(src0), .o_ack_tgl(ack0),
        .o_data(dat0), .o_valid(val0), .i_ready(rdy0), .o_pend(pend0));

    bus_sync_rx_mc #(.DWIDTH(32), .NCH(4), .SYNC_STAGES(2), .ACK_MODE(1)) dut1 (
        .i_clk(i_clk), .rst(rst), .i_req_tgl(req1), .i_src_data(src1), .o_ack_tgl(ack1),
        .o_data(dat1), .o_valid(val1), .i_ready(rdy1), .o_pend(pend1));

    bus_sync_rx_mc #(.DWIDTH(8), .NCH(1), .SYNC_STAGES(3), .ACK_MODE(0)) dut2 (
        .i_clk(i_clk), .rst(rst), .i_req_tgl(req2), .i_src_data(src2), .o_ack_tgl(ack2),
        .o_data(dat2), .o_valid(val2), .i_ready(rdy2), .o_pend(pend2));

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: one held word and at most one word in flight (sender waits for ack).
    logic        m_valid [3][4];
    logic [31:0] m_data  [3][4];
    logic        m_ack   [3][4];
    logic        m_pv    [3][4];
    int          m_pt    [3][4];
    logic [31:0] m_pd    [3][4];
    logic        rdy_snap[3][4];

    function automatic int nch_of(int d);
        return (d == 2) ? 1 : 4;
    endfunction

    function automatic int s_of(int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic logic a_valid(int d, int c);
        case (d)
            0: return val0[c];
            1: return val1[c];
            default: return val2[0];
        endcase
    endfunction

    function automatic logic a_ack(int d, int c);
        case (d)
            0: return ack0[c];
            1: return ack1[c];
            default: return ack2[0];
        endcase
    endfunction

    function automatic logic a_pend(int d, int c);
        case (d)
            0: return pend0[c];
            1: return pend1[c];
            default: return pend2[0];
        endcase
    endfunction

    function automatic logic [31:0] a_data(int d, int c);
        case (d)
            0: return dat0[c*32 +: 32];
            1: return dat1[c*32 +: 32];
            default: return {24'h0, dat2};
        endcase
    endfunction

    function automatic logic a_tgl(int d, int c);
        case (d)
            0: return req0[c];
            1: return req1[c];
            default: return req2[0];
        endcase
    endfunction

    function automatic logic a_rdy(int d, int c);
        case (d)
            0: return rdy0[c];
            1: return rdy1[c];
            default: return rdy2[0];
        endcase
    endfunction

    // New word from the sender; first sync flop samples it at edge cyc+1, capturable at cyc+1+S.
    task automatic drive_req(int d, int c, logic [31:0] data);
        case (d)
            0: begin req0[c] = ~req0[c]; src0[c*32 +: 32] = data; end
            1: begin req1[c] = ~req1[c]; src1[c*32 +: 32] = data; end
            default: begin req2[0] = ~req2[0]; src2 = data[7:0]; end
        endcase
        m_pv[d][c] = 1'b1;
        m_pt[d][c] = cyc + 1 + s_of(d);
        m_pd[d][c] = (d == 2) ? {24'h0, data[7:0]} : data;
    endtask

    task automatic set_ready(int d, int c, logic v);
        case (d)
            0: rdy0[c] = v;
            1: rdy1[c] = v;
            default: rdy2[0] = v;
        endcase
    endtask

    task automatic tick();
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < nch_of(d); c++)
                rdy_snap[d][c] = a_rdy(d, c);
        @(posedge i_clk);
        #1;
        cyc++;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < nch_of(d); c++) begin
                    if (m_valid[d][c] && rdy_snap[d][c]) begin
                        m_valid[d][c] = 1'b0;
                        if (d == 1) m_ack[d][c] = ~m_ack[d][c];
                    end
                    if (!m_valid[d][c] && m_pv[d][c] && m_pt[d][c] <= cyc) begin
                        m_valid[d][c] = 1'b1;
                        m_data[d][c]  = m_pd[d][c];
                        m_pv[d][c]    = 1'b0;
                        if (d != 1) m_ack[d][c] = ~m_ack[d][c];
                    end
                end
            end
        end
    endtask

    task automatic assert_reset();
        rst  = 1'b1;
        req0 = '0; req1 = '0; req2 = '0;
        src0 = '0; src1 = '0; src2 = '0;
        rdy0 = '1; rdy1 = '1; rdy2 = '1;
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 4; c++) begin
                m_valid[d][c] = 1'b0; m_data[d][c] = '0; m_ack[d][c] = 1'b0;
                m_pv[d][c] = 1'b0; m_pt[d][c] = 0; m_pd[d][c] = '0;
            end
        #1;
    endtask

    task automatic release_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        assert_reset();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < nch_of(d); c++) begin
                n_vec++;
                if ({a_valid(d, c), a_ack(d, c), a_pend(d, c), a_data(d, c)} !== 35'h0) begin
                    n_err++;
                    $display("FAIL reset d%0d c%0d got v=%b a=%b p=%b data=%h want all zero",
                             d, c, a_valid(d, c), a_ack(d, c), a_pend(d, c), a_data(d, c));
                end
            end
        end
        release_reset();
    endtask

    task automatic test_latency_m0();
        assert_reset();
        release_reset();
        drive_req(0, 0, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (val0[0] !== 1'b0) begin
                n_err++;
                $display("FAIL lat0_early step%0d got valid=%b want 0", i, val0[0]);
            end
        end
        tick();
        n_vec++;
        if ({val0[0], ack0[0], dat0[31:0]} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL lat0_capture got v=%b a=%b d=%h want v=1 a=1 d=deadbeef",
                     val0[0], ack0[0], dat0[31:0]);
        end
        tick();
        n_vec++;
        if ({val0[0], ack0[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL lat0_consume got v=%b a=%b want v=0 a=1", val0[0], ack0[0]);
        end
    endtask

    task automatic test_backpressure_m1();
        assert_reset();
        release_reset();
        set_ready(1, 1, 1'b0);
        drive_req(1, 1, 32'h00000055);
        repeat (3) tick();
        for (int i = 0; i <= 20; i++) begin
            n_vec++;
            if ({val1[1], ack1[1], dat1[63:32]} !== {1'b1, 1'b0, 32'h55}) begin
                n_err++;
                $display("FAIL bp1_hold step%0d got v=%b a=%b d=%h want v=1 a=0 d=00000055",
                         i, val1[1], ack1[1], dat1[63:32]);
            end
            if (i < 20) tick();
        end
        set_ready(1, 1, 1'b1);
        tick();
        n_vec++;
        if ({val1[1], ack1[1]} !== 2'b01) begin
            n_err++;
            $display("FAIL bp1_release got v=%b a=%b want v=0 a=1", val1[1], ack1[1]);
        end
    endtask

    task automatic test_pend_m0();
        assert_reset();
        release_reset();
        set_ready(0, 2, 1'b0);
        drive_req(0, 2, 32'h1);
        repeat (3) tick();
        n_vec++;
        if ({val0[2], ack0[2], pend0[2], dat0[95:64]} !== {3'b110, 32'h1}) begin
            n_err++;
            $display("FAIL pend_first got v=%b a=%b p=%b d=%h want v=1 a=1 p=0 d=1",
                     val0[2], ack0[2], pend0[2], dat0[95:64]);
        end
        drive_req(0, 2, 32'h2);
        tick();
        n_vec++;
        if (pend0[2] !== 1'b0) begin
            n_err++;
            $display("FAIL pend_early got p=%b want 0", pend0[2]);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if ({val0[2], ack0[2], pend0[2], dat0[95:64]} !== {3'b111, 32'h1}) begin
                n_err++;
                $display("FAIL pend_wait step%0d got v=%b a=%b p=%b d=%h want v=1 a=1 p=1 d=1",
                         i, val0[2], ack0[2], pend0[2], dat0[95:64]);
            end
        end
        set_ready(0, 2, 1'b1);
        tick();
        n_vec++;
        if ({val0[2], ack0[2], pend0[2], dat0[95:64]} !== {3'b100, 32'h2}) begin
            n_err++;
            $display("FAIL pend_b2b got v=%b a=%b p=%b d=%h want v=1 a=0 p=0 d=2",
                     val0[2], ack0[2], pend0[2], dat0[95:64]);
        end
        tick();
        n_vec++;
        if (val0[2] !== 1'b0) begin
            n_err++;
            $display("FAIL pend_drain got v=%b want 0", val0[2]);
        end
    endtask

    task automatic test_all_channels();
        assert_reset();
        release_reset();
        set_ready(0, 3, 1'b0);
        for (int c = 0; c < 4; c++) drive_req(0, c, 32'h11 * (c + 1));
        repeat (3) tick();
        for (int c = 0; c < 4; c++) begin
            n_vec++;
            if ({val0[c], ack0[c], dat0[c*32 +: 32]} !== {2'b11, 32'h11 * (c + 1)}) begin
                n_err++;
                $display("FAIL allch_capture c%0d got v=%b a=%b d=%h want v=1 a=1 d=%h",
                         c, val0[c], ack0[c], dat0[c*32 +: 32], 32'h11 * (c + 1));
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if ({val0, dat0[127:96]} !== {4'b1000, 32'h44}) begin
                n_err++;
                $display("FAIL allch_hold step%0d got valid=%b d3=%h want valid=1000 d3=44",
                         i, val0, dat0[127:96]);
            end
        end
        set_ready(0, 3, 1'b1);
        tick();
        n_vec++;
        if ({val0, ack0} !== 8'h0F) begin
            n_err++;
            $display("FAIL allch_drain got valid=%b ack=%b want 0000 1111", val0, ack0);
        end
    endtask

    task automatic test_reset_midflight();
        assert_reset();
        release_reset();
        set_ready(0, 0, 1'b0);
        drive_req(0, 0, 32'hA0A0A0A0);
        repeat (3) tick();
        drive_req(0, 1, 32'hB1B1B1B1);
        tick();
        assert_reset();
        n_vec++;
        if ({val0, pend0, ack0, dat0} !== 140'h0) begin
            n_err++;
            $display("FAIL rstmid_async got v=%b p=%b a=%b d=%h want all zero",
                     val0, pend0, ack0, dat0);
        end
        release_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if ({val0, pend0, ack0} !== 12'h0) begin
                n_err++;
                $display("FAIL rstmid_after step%0d got v=%b p=%b a=%b want zero",
                         i, val0, pend0, ack0);
            end
        end
    endtask

    task automatic test_sync3_latency();
        int n;
        assert_reset();
        release_reset();
        drive_req(2, 0, 32'hA5);
        n = 0;
        do begin
            tick();
            n++;
        end while (val2[0] !== 1'b1 && n < 10);
        n_vec++;
        if ((n - 1) != 3 || dat2 !== 8'hA5) begin
            n_err++;
            $display("FAIL sync3_latency got edges=%0d d=%h want edges=3 d=a5", n - 1, dat2);
        end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        for (int it = 0; it < 3000; it++) begin
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < nch_of(d); c++) begin
                    set_ready(d, c, ($urandom_range(3) != 0));
                    if (a_tgl(d, c) == m_ack[d][c] && $urandom_range(2) == 0)
                        drive_req(d, c, $urandom);
                end
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                for (int c = 0; c < nch_of(d); c++) begin
                    logic exp_pend;
                    exp_pend = m_valid[d][c] && m_pv[d][c] && (m_pt[d][c] <= cyc + 1);
                    n_vec++;
                    if (a_valid(d, c) !== m_valid[d][c]) begin
                        n_err++;
                        $display("FAIL rnd_valid cyc%0d d%0d c%0d got %b want %b",
                                 cyc, d, c, a_valid(d, c), m_valid[d][c]);
                    end
                    n_vec++;
                    if (a_data(d, c) !== m_data[d][c]) begin
                        n_err++;
                        $display("FAIL rnd_data cyc%0d d%0d c%0d got %h want %h",
                                 cyc, d, c, a_data(d, c), m_data[d][c]);
                    end
                    n_vec++;
                    if (a_ack(d, c) !== m_ack[d][c]) begin
                        n_err++;
                        $display("FAIL rnd_ack cyc%0d d%0d c%0d got %b want %b",
                                 cyc, d, c, a_ack(d, c), m_ack[d][c]);
                    end
                    n_vec++;
                    if (a_pend(d, c) !== exp_pend) begin
                        n_err++;
                        $display("FAIL rnd_pend cyc%0d d%0d c%0d got %b want %b",
                                 cyc, d, c, a_pend(d, c), exp_pend);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency_m0();
        test_backpressure_m1();
        test_pend_m0();
        test_all_channels();
        test_reset_midflight();
        test_sync3_latency();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_sync_rx_mc.md
Name: bus_sync_rx_mc

Overview:
- Multi-channel, destination-side receiver for toggle-handshake bus synchronisation.
- Each channel takes an asynchronous request toggle and a held-stable data word from a foreign clock domain. It synchronises the toggle, captures the word into the local domain and presents it on a valid/ready interface with backpressure.
- Each channel returns an ack toggle for the remote sender's synchroniser.
- Sits at the boundary of the destination clock domain. One instance serves NCH independent channels.

Parameters:
- DWIDTH, 32, data width per channel.
- NCH, 4, number of independent channels.
- SYNC_STAGES, 2, flops in each request-toggle synchroniser chain. Values below 2 are an elaboration error.
- ACK_MODE, 0, 0 = ack on capture (early ack, allows overlap); 1 = ack on consumption (ack when the word leaves via i_ready).

Ports:
- i_clk  input  1  destination clock; all state is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_req_tgl  input  NCH  per-channel request toggle, asynchronous to i_clk. Each transition is one new word.
- i_src_data  input  NCH*DWIDTH  channel c occupies bits [c*DWIDTH +: DWIDTH]. Asynchronous; sender holds it stable from req toggle until the matching ack toggle is seen.
- o_ack_tgl  output  NCH  per-channel ack toggle, registered, returned to the sender domain.
- o_data  output  NCH*DWIDTH  captured word per channel, same packing as i_src_data.
- o_valid  output  NCH  channel holds an unconsumed word.
- i_ready  input  NCH  consumer accepts channel word when o_valid[c] and i_ready[c] are both high at a rising edge.
- o_pend  output  NCH  a synchronised request edge is waiting because the output register is still full.

Behaviour:
- Reset (async assert, released synchronously by the integrator): all sync flops, req_seen, o_ack_tgl, o_valid, o_pend and o_data clear to 0. The sender's toggles must also reset to 0.
- Reset mid-transfer: an in-flight or held word is discarded with no ack. The sender domain must be reset in the same event.
- Sync chain per channel: SYNC_STAGES flops. req_s is the last stage; earlier stages are never used in logic.
- Edge detect: edge[c] = req_s[c] ^ req_seen[c]. This is level-based, so a held edge is never lost.
- Per-channel FSM, EMPTY / FULL; o_valid[c] = (state == FULL):
  - EMPTY, edge=1 -> capture i_src_data slice into o_data, toggle req_seen, go to FULL. If ACK_MODE=0, toggle o_ack_tgl on the same edge.
  - FULL, o_valid & i_ready, edge=0 -> go to EMPTY. If ACK_MODE=1, toggle o_ack_tgl on that edge.
  - FULL, o_valid & i_ready, edge=1 (possible only in ACK_MODE=0) -> recapture the new word, toggle req_seen and o_ack_tgl, stay FULL. This gives back-to-back transfer with no bubble.
  - FULL, i_ready=0 -> hold o_data and o_valid. A pending edge waits; req_seen is not updated.
- o_pend[c] = (state == FULL) & edge[c], combinational from registered state.
- o_data changes only on a capture edge; it is stable while o_valid=1 and i_ready=0.
- Latency: if the sender toggles req and the first sync flop samples the new value at rising edge k, o_valid rises at edge k+SYNC_STAGES, provided the channel is EMPTY. Ack follows:
  - ACK_MODE=0: ack toggles at that same edge.
  - ACK_MODE=1: ack toggles at the edge where the handshake completes.
- Minimum per-word cycle, excluding sender-side sync:
  - ACK_MODE=0 with i_ready tied high: one word per SYNC_STAGES+1 round-trip, limited by the sender.
  - ACK_MODE=1: adds one cycle of consumer acceptance.
- Channels are fully independent. Simultaneous events on different channels never interact.
- No overrun is possible: the protocol forbids the sender from toggling again before the ack arrives. No error output is needed.
- Data is never passed through a sync chain. Capture safety relies on the sender's stability contract. i_src_data is tagged as a false/max-delay path in constraints.

Test Plan:
- ACK_MODE=0, SYNC_STAGES=2, ch0 data 0xDEADBEEF, toggle i_req_tgl[0] 0->1 sampled at edge 10, i_ready=1 -> o_valid[0]=1 and o_data[0]=0xDEADBEEF at edge 12. o_ack_tgl[0]=1 from edge 12; o_valid[0]=0 at edge 13.
- ACK_MODE=1, i_ready[1]=0 for 20 cycles after o_valid[1] rises with 0x00000055 -> o_data held, o_ack_tgl[1] unchanged. Raise i_ready at edge N -> o_valid drops and ack toggles at edge N.
- ACK_MODE=0, i_ready[2]=0, second toggle with 0x2 while word 0x1 is held -> o_pend[2]=1, o_data stays 0x1. Raise i_ready -> next edge o_data=0x2, o_valid stays 1, o_pend=0, ack toggles.
- All 4 channels toggled in the same cycle with distinct data 0x11/0x22/0x33/0x44, and ch3 ready held low -> ch0-2 complete on schedule and ch3 holds 0x44 independently.
- Assert rst while ch0 is FULL and ch1 is mid-sync -> o_valid=0, o_pend=0, o_ack_tgl=0, o_data=0 immediately. After release with the sender toggles at 0 -> no spurious valid.
- SYNC_STAGES=3, DWIDTH=8, NCH=1 elaboration -> latency measures 3 edges. SYNC_STAGES=1 -> elaboration fails.
